// File: rtl/wb_bus_ctrl_pkg.sv
// Shared definitions for the Wishbone bus controller and its address decoder.
package wb_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Slave index field is wide enough for indices 0..7 plus the miss sentinel.
  localparam int               SEL_W        = 4;
  localparam logic [SEL_W-1:0] NO_SLAVE     = 4'd8;
  localparam logic [31:0]      DEF_ERR_DATA = 32'hDEADBEEF;

  // Watchdog counter width; a disabled watchdog still keeps a 1-bit counter.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational base/mask address decoder with lowest-index priority.
module wb_addr_decode
  import wb_bus_ctrl_pkg::*;
#(
  parameter int              NS       = 4,
  parameter logic [32*NS-1:0] SLV_BASE = '0,
  parameter logic [32*NS-1:0] SLV_MASK = '0
) (
  input  logic [31:0]      adr,
  output logic             hit,
  output logic [SEL_W-1:0] idx
);

  // Scan from the top so the lowest matching window is the last writer.
  always_comb begin
    hit = 1'b0;
    idx = NO_SLAVE;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((adr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit = 1'b1;
        idx = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/wb_bus_ctrl.sv
// Wishbone sequencing controller: registered decode, one slave strobe per
// transaction, registered ack/err/data back to the master, timeout watchdog.
// Optional fault capture is enabled with `define BUS_FAULT_CAPTURE_EN.
//
// state     | meaning
// ST_IDLE   | waiting for master cyc & stb, counter cleared
// ST_DECODE | address and slave index registered, choose access or error
// ST_ACCESS | selected slave strobed, watchdog counting
// ST_RESP   | one-cycle ack or err to master
module wb_bus_ctrl
  import wb_bus_ctrl_pkg::*;
#(
  parameter int               NS       = 4,
  parameter logic [32*NS-1:0] SLV_BASE = {32'h08000100, 32'h08000000,
                                          32'h00010000, 32'h00000000},
  parameter logic [32*NS-1:0] SLV_MASK = {32'hFFFFFFF0, 32'hFFFFFFF0,
                                          32'hFFFF0000, 32'hFFFF0000},
  parameter int               TIMEOUT  = 255,
  parameter logic [31:0]      ERR_DATA = DEF_ERR_DATA
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [31:0]      m_wb_adr_i,
  input  logic             m_wb_cyc_i,
  input  logic             m_wb_stb_i,
  output logic [31:0]      m_wb_dat_o,
  output logic             m_wb_ack_o,
  output logic             m_wb_err_o,
  output logic [NS-1:0]    s_wb_stb_o,
  input  logic [32*NS-1:0] s_wb_dat_i,
  input  logic [NS-1:0]    s_wb_ack_i,
  output logic             busy_o,
  output logic [31:0]      fault_adr_o,
  output logic             fault_valid_o,
  input  logic             fault_clr_i
);

  localparam int          CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);

  state_t           state;
  logic [SEL_W-1:0] sel_q;
  logic [31:0]      adr_q;
  logic [CW-1:0]    cnt_q;

  logic             dec_hit;
  logic [SEL_W-1:0] dec_idx;
  logic             ack_sel;
  logic [31:0]      dat_sel;
  logic [NS-1:0]    stb_sel;
  logic [CW-1:0]    cnt_inc;
  logic             timeout_hit;
  logic             miss;
  logic             err_set;

  wb_addr_decode #(
    .NS       (NS),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_addr_decode (
    .adr (m_wb_adr_i),
    .hit (dec_hit),
    .idx (dec_idx)
  );

  // Route the selected slave's ack/data and build its one-hot strobe.
  always_comb begin
    ack_sel = 1'b0;
    dat_sel = '0;
    stb_sel = '0;
    for (int i = 0; i < NS; i++) begin
      if (sel_q == SEL_W'(i)) begin
        ack_sel    = s_wb_ack_i[i];
        dat_sel    = s_wb_dat_i[32*i +: 32];
        stb_sel[i] = 1'b1;
      end
    end
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);
    miss        = (sel_q == NO_SLAVE);
    err_set     = m_wb_cyc_i &&
                  (((state == ST_DECODE) && miss) ||
                   ((state == ST_ACCESS) && !ack_sel && timeout_hit));
  end

  // Transaction sequencer with registered master/slave outputs and watchdog.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state      <= ST_IDLE;
      sel_q      <= NO_SLAVE;
      adr_q      <= '0;
      cnt_q      <= '0;
      m_wb_dat_o <= '0;
      m_wb_ack_o <= 1'b0;
      m_wb_err_o <= 1'b0;
      s_wb_stb_o <= '0;
      busy_o     <= 1'b0;
    end else begin
      m_wb_ack_o <= 1'b0;
      m_wb_err_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt_q <= '0;
          if (m_wb_cyc_i && m_wb_stb_i) begin
            state  <= ST_DECODE;
            adr_q  <= m_wb_adr_i;
            sel_q  <= dec_hit ? dec_idx : NO_SLAVE;
            busy_o <= 1'b1;
          end
        end
        ST_DECODE: begin
          if (!m_wb_cyc_i) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end else if (miss) begin
            state      <= ST_RESP;
            m_wb_err_o <= 1'b1;
            m_wb_dat_o <= ERR_DATA;
          end else begin
            state      <= ST_ACCESS;
            s_wb_stb_o <= stb_sel;
          end
        end
        ST_ACCESS: begin
          if (!m_wb_cyc_i) begin
            state      <= ST_IDLE;
            s_wb_stb_o <= '0;
            cnt_q      <= '0;
            busy_o     <= 1'b0;
          end else if (ack_sel) begin
            state      <= ST_RESP;
            m_wb_ack_o <= 1'b1;
            m_wb_dat_o <= dat_sel;
            s_wb_stb_o <= '0;
            cnt_q      <= '0;
          end else if (timeout_hit) begin
            state      <= ST_RESP;
            m_wb_err_o <= 1'b1;
            m_wb_dat_o <= ERR_DATA;
            s_wb_stb_o <= '0;
            cnt_q      <= '0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        ST_RESP: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
        default: begin
          state      <= ST_IDLE;
          s_wb_stb_o <= '0;
          busy_o     <= 1'b0;
        end
      endcase
    end
  end

`ifdef BUS_FAULT_CAPTURE_EN
  // Sticky fault capture; a new fault outranks a simultaneous clear.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      fault_adr_o   <= '0;
      fault_valid_o <= 1'b0;
    end else if (err_set) begin
      fault_adr_o   <= adr_q;
      fault_valid_o <= 1'b1;
    end else if (fault_clr_i) begin
      fault_valid_o <= 1'b0;
    end
  end
`else
  logic unused_fault;
  assign unused_fault  = fault_clr_i ^ err_set ^ (^adr_q);
  assign fault_adr_o   = '0;
  assign fault_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_bus_ctrl.sv
// Directed self-checking bench for wb_bus_ctrl (TIMEOUT=8, slaves 0/1 overlap).
module tb_wb_bus_ctrl;

  localparam int NS = 4;

  logic            wb_clk_i = 1'b0;
  logic            wb_rst_i;
  logic [31:0]     m_wb_adr_i;
  logic            m_wb_cyc_i;
  logic            m_wb_stb_i;
  logic [31:0]     m_wb_dat_o;
  logic            m_wb_ack_o;
  logic            m_wb_err_o;
  logic [NS-1:0]   s_wb_stb_o;
  logic [32*NS-1:0] s_wb_dat_i;
  logic [NS-1:0]   s_wb_ack_i;
  logic            busy_o;
  logic [31:0]     fault_adr_o;
  logic            fault_valid_o;
  logic            fault_clr_i;

  int n_cmp  = 0;
  int n_fail = 0;

`ifdef BUS_FAULT_CAPTURE_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  wb_bus_ctrl #(
    .NS       (NS),
    .SLV_BASE ({32'h08000100, 32'h08000000, 32'h00000000, 32'h00000000}),
    .SLV_MASK ({32'hFFFFFFF0, 32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFF0000}),
    .TIMEOUT  (8),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .wb_clk_i      (wb_clk_i),
    .wb_rst_i      (wb_rst_i),
    .m_wb_adr_i    (m_wb_adr_i),
    .m_wb_cyc_i    (m_wb_cyc_i),
    .m_wb_stb_i    (m_wb_stb_i),
    .m_wb_dat_o    (m_wb_dat_o),
    .m_wb_ack_o    (m_wb_ack_o),
    .m_wb_err_o    (m_wb_err_o),
    .s_wb_stb_o    (s_wb_stb_o),
    .s_wb_dat_i    (s_wb_dat_i),
    .s_wb_ack_i    (s_wb_ack_i),
    .busy_o        (busy_o),
    .fault_adr_o   (fault_adr_o),
    .fault_valid_o (fault_valid_o),
    .fault_clr_i   (fault_clr_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic master(input logic [31:0] adr, input logic on);
    m_wb_adr_i = adr;
    m_wb_cyc_i = on;
    m_wb_stb_i = on;
  endtask

  task automatic check_fault(input string tag, input logic [31:0] adr, input logic vld);
    check({tag, "_fadr"}, fault_adr_o, FEAT ? adr : 32'h0);
    check({tag, "_fvld"}, {31'b0, fault_valid_o}, {31'b0, FEAT ? vld : 1'b0});
  endtask

  initial begin
    wb_rst_i    = 1'b0;
    fault_clr_i = 1'b0;
    s_wb_ack_i  = '0;
    s_wb_dat_i  = {32'hCAFEF00D, 32'h22222222, 32'h11111111, 32'h12345678};
    master(32'h0, 1'b0);
    tick();
    tick();
    check("rst_ack",  {31'b0, m_wb_ack_o}, 32'h0);
    check("rst_err",  {31'b0, m_wb_err_o}, 32'h0);
    check("rst_dat",  m_wb_dat_o, 32'h0);
    check("rst_stb",  {28'b0, s_wb_stb_o}, 32'h0);
    check("rst_busy", {31'b0, busy_o}, 32'h0);
    check_fault("rst", 32'h0, 1'b0);
    wb_rst_i = 1'b1;
    tick();

    // Read slave 0 with a one-cycle slave.
    master(32'h00000010, 1'b1);
    tick();
    check("rd0_c1_stb",  {28'b0, s_wb_stb_o}, 32'h0);
    check("rd0_c1_busy", {31'b0, busy_o}, 32'h1);
    tick();
    check("rd0_c2_stb", {28'b0, s_wb_stb_o}, 32'h1);
    check("rd0_c2_ack", {31'b0, m_wb_ack_o}, 32'h0);
    s_wb_ack_i = 4'b0001;
    tick();
    check("rd0_c3_ack", {31'b0, m_wb_ack_o}, 32'h1);
    check("rd0_c3_err", {31'b0, m_wb_err_o}, 32'h0);
    check("rd0_c3_dat", m_wb_dat_o, 32'h12345678);
    check("rd0_c3_stb", {28'b0, s_wb_stb_o}, 32'h0);
    s_wb_ack_i = '0;
    master(32'h0, 1'b0);
    tick();
    check("rd0_c4_ack",  {31'b0, m_wb_ack_o}, 32'h0);
    check("rd0_c4_busy", {31'b0, busy_o}, 32'h0);
    check("rd0_c4_dat",  m_wb_dat_o, 32'h12345678);

    // Unmapped access.
    master(32'h20000000, 1'b1);
    tick();
    check("um_c1_stb", {28'b0, s_wb_stb_o}, 32'h0);
    tick();
    check("um_c2_err", {31'b0, m_wb_err_o}, 32'h1);
    check("um_c2_ack", {31'b0, m_wb_ack_o}, 32'h0);
    check("um_c2_dat", m_wb_dat_o, 32'hDEADBEEF);
    check("um_c2_stb", {28'b0, s_wb_stb_o}, 32'h0);
    check_fault("um_c2", 32'h20000000, 1'b1);
    master(32'h0, 1'b0);
    tick();
    check("um_c3_err", {31'b0, m_wb_err_o}, 32'h0);

    // Slave 2 never acks: watchdog after 8 strobe cycles.
    master(32'h08000008, 1'b1);
    tick();
    tick();
    check("to_c2_stb", {28'b0, s_wb_stb_o}, 32'h4);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("to_wait_stb", {28'b0, s_wb_stb_o}, 32'h4);
      check("to_wait_err", {31'b0, m_wb_err_o}, 32'h0);
    end
    tick();
    check("to_err",  {31'b0, m_wb_err_o}, 32'h1);
    check("to_stb",  {28'b0, s_wb_stb_o}, 32'h0);
    check("to_dat",  m_wb_dat_o, 32'hDEADBEEF);
    check_fault("to", 32'h08000008, 1'b1);
    master(32'h0, 1'b0);
    tick();
    fault_clr_i = 1'b1;
    tick();
    fault_clr_i = 1'b0;
    check_fault("clr", 32'h08000008, 1'b0);

    // Master abort during ACCESS, late slave ack ignored.
    master(32'h08000004, 1'b1);
    tick();
    tick();
    check("ab_stb", {28'b0, s_wb_stb_o}, 32'h4);
    master(32'h0, 1'b0);
    tick();
    check("ab_idle_stb",  {28'b0, s_wb_stb_o}, 32'h0);
    check("ab_idle_busy", {31'b0, busy_o}, 32'h0);
    tick();
    s_wb_ack_i = 4'b0100;
    tick();
    check("ab_late_ack", {31'b0, m_wb_ack_o}, 32'h0);
    check("ab_late_err", {31'b0, m_wb_err_o}, 32'h0);
    s_wb_ack_i = '0;

    // Follow-up read to slave 3.
    master(32'h08000104, 1'b1);
    tick();
    tick();
    check("rd3_stb", {28'b0, s_wb_stb_o}, 32'h8);
    s_wb_ack_i = 4'b1000;
    tick();
    check("rd3_ack", {31'b0, m_wb_ack_o}, 32'h1);
    check("rd3_dat", m_wb_dat_o, 32'hCAFEF00D);
    s_wb_ack_i = '0;
    master(32'h0, 1'b0);
    tick();

    // Reset asserted in ACCESS.
    master(32'h00000020, 1'b1);
    tick();
    tick();
    check("rs_stb", {28'b0, s_wb_stb_o}, 32'h1);
    wb_rst_i = 1'b0;
    master(32'h0, 1'b0);
    tick();
    check("rs_ack",  {31'b0, m_wb_ack_o}, 32'h0);
    check("rs_err",  {31'b0, m_wb_err_o}, 32'h0);
    check("rs_dat",  m_wb_dat_o, 32'h0);
    check("rs_stb0", {28'b0, s_wb_stb_o}, 32'h0);
    check("rs_busy", {31'b0, busy_o}, 32'h0);
    check_fault("rs", 32'h0, 1'b0);
    wb_rst_i   = 1'b1;
    s_wb_ack_i = 4'b0001;
    tick();
    s_wb_ack_i = '0;
    tick();
    check("rs_stray_ack", {31'b0, m_wb_ack_o}, 32'h0);
    check("rs_stray_busy", {31'b0, busy_o}, 32'h0);

    // Overlapping windows: slave 0 wins; slave 1 ack ignored; fault beats clear.
    fault_clr_i = 1'b1;
    master(32'h00000040, 1'b1);
    tick();
    tick();
    check("ov_stb", {28'b0, s_wb_stb_o}, 32'h1);
    s_wb_ack_i = 4'b0010;
    for (int k = 0; k < 7; k++) begin
      tick();
      check("ov_wait_ack", {31'b0, m_wb_ack_o}, 32'h0);
      check("ov_wait_stb", {28'b0, s_wb_stb_o}, 32'h1);
    end
    tick();
    check("ov_err", {31'b0, m_wb_err_o}, 32'h1);
    check("ov_ack", {31'b0, m_wb_ack_o}, 32'h0);
    check("ov_dat", m_wb_dat_o, 32'hDEADBEEF);
    check_fault("ov", 32'h00000040, 1'b1);
    s_wb_ack_i  = '0;
    fault_clr_i = 1'b0;
    master(32'h0, 1'b0);
    tick();
    check("ov_end_err", {31'b0, m_wb_err_o}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
